// File: rtl/lcd_vram_fill.sv
// Per-frame copier: reads the 1 bpp LCD bitmap from system memory and writes it
// as 4-bit nibbles into VRAM, or blanks VRAM when the LCD is off.
module lcd_vram_fill #(
    parameter int unsigned LINES          = 64,
    parameter int unsigned BYTES_PER_LINE = 80,
    parameter bit          INVERT         = 1'b0
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic        lcdon,
    input  logic        frame_start,
    input  logic [21:0] base_addr,
    output logic        mem_req,
    output logic [21:0] mem_a,
    input  logic        mem_ack,
    input  logic [7:0]  mem_di,
    output logic        vram_we,
    output logic [13:0] vram_wa,
    output logic [3:0]  vram_do,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, FETCH, WR_HI, WR_LO, BLANK} state_t;

    localparam logic [5:0] LAST_LINE = 6'(LINES - 1);
    localparam logic [6:0] LAST_COL  = 7'(BYTES_PER_LINE - 1);
    localparam logic [3:0] INV_MASK  = INVERT ? 4'hF : 4'h0;

    state_t      state_q, state_d;
    logic [5:0]  line_q, line_d;
    logic [6:0]  col_q, col_d;
    logic        half_q, half_d;
    logic [21:0] base_q, base_d;
    logic [3:0]  lo_q, lo_d;
    logic        mem_req_q, mem_req_d;
    logic [21:0] mem_a_q, mem_a_d;
    logic        vram_we_q, vram_we_d;
    logic [13:0] vram_wa_q, vram_wa_d;
    logic [3:0]  vram_do_q, vram_do_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;

    logic        last_col, last_byte;
    logic [5:0]  next_line;
    logic [6:0]  next_col;

    function automatic logic [21:0] src_addr(input logic [21:0] base,
                                             input logic [5:0]  line,
                                             input logic [6:0]  col);
        return base + 22'(line) * 22'(BYTES_PER_LINE) + 22'(col);
    endfunction

    always_comb begin
        last_col  = (col_q == LAST_COL);
        last_byte = last_col && (line_q == LAST_LINE);
        next_col  = last_col ? '0 : col_q + 7'd1;
        next_line = last_col ? line_q + 6'd1 : line_q;
    end

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        col_d        = col_q;
        half_d       = half_q;
        base_d       = base_q;
        lo_d         = lo_q;
        mem_req_d    = mem_req_q;
        mem_a_d      = mem_a_q;
        vram_we_d    = vram_we_q;
        vram_wa_d    = vram_wa_q;
        vram_do_d    = vram_do_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = frame_start && (state_q != IDLE);

        // Outputs are registered, so each state's outputs are set on entry.
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    base_d = base_addr;
                    line_d = '0;
                    col_d  = '0;
                    half_d = 1'b0;
                    busy_d = 1'b1;
                    if (lcdon) begin
                        state_d   = FETCH;
                        mem_req_d = 1'b1;
                        mem_a_d   = base_addr;
                    end else begin
                        state_d   = BLANK;
                        vram_we_d = 1'b1;
                        vram_wa_d = '0;
                        vram_do_d = '0;
                    end
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    state_d   = WR_HI;
                    mem_req_d = 1'b0;
                    lo_d      = mem_di[3:0];
                    vram_we_d = 1'b1;
                    vram_wa_d = {line_q, col_q, 1'b0};
                    vram_do_d = mem_di[7:4] ^ INV_MASK;
                end
            end
            WR_HI: begin
                state_d   = WR_LO;
                vram_wa_d = {line_q, col_q, 1'b1};
                vram_do_d = lo_q ^ INV_MASK;
            end
            WR_LO: begin
                vram_we_d = 1'b0;
                if (last_byte) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    state_d   = FETCH;
                    line_d    = next_line;
                    col_d     = next_col;
                    mem_req_d = 1'b1;
                    mem_a_d   = src_addr(base_q, next_line, next_col);
                end
            end
            BLANK: begin
                if (!half_q) begin
                    half_d    = 1'b1;
                    vram_wa_d = {line_q, col_q, 1'b1};
                end else if (last_byte) begin
                    state_d      = IDLE;
                    vram_we_d    = 1'b0;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    half_d    = 1'b0;
                    line_d    = next_line;
                    col_d     = next_col;
                    vram_wa_d = {next_line, next_col, 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            line_q       <= '0;
            col_q        <= '0;
            half_q       <= 1'b0;
            base_q       <= '0;
            lo_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_a_q      <= '0;
            vram_we_q    <= 1'b0;
            vram_wa_q    <= '0;
            vram_do_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            col_q        <= col_d;
            half_q       <= half_d;
            base_q       <= base_d;
            lo_q         <= lo_d;
            mem_req_q    <= mem_req_d;
            mem_a_q      <= mem_a_d;
            vram_we_q    <= vram_we_d;
            vram_wa_q    <= vram_wa_d;
            vram_do_q    <= vram_do_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_a      = mem_a_q;
    assign vram_we    = vram_we_q;
    assign vram_wa    = vram_wa_q;
    assign vram_do    = vram_do_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_lcd_vram_fill.sv
// Directed bench: full-size instance with zero-wait memory, plus a small
// inverted instance driven by a memory with random wait states.
module tb_lcd_vram_fill;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance 0: default parameters, zero-wait memory
    logic        reset0 = 1'b1, lcdon0 = 1'b0, frame_start0 = 1'b0;
    logic [21:0] base_addr0 = '0;
    logic        mem_req0, mem_ack0, vram_we0, busy0, frame_done0, overrun0;
    logic [21:0] mem_a0, off0;
    logic [7:0]  mem_di0;
    logic [13:0] vram_wa0;
    logic [3:0]  vram_do0;

    assign mem_ack0 = mem_req0;
    assign off0     = mem_a0 - base_addr0;
    assign mem_di0  = off0[7:0];

    lcd_vram_fill dut0 (
        .clk25(clk), .reset(reset0), .lcdon(lcdon0), .frame_start(frame_start0),
        .base_addr(base_addr0), .mem_req(mem_req0), .mem_a(mem_a0), .mem_ack(mem_ack0),
        .mem_di(mem_di0), .vram_we(vram_we0), .vram_wa(vram_wa0), .vram_do(vram_do0),
        .busy(busy0), .frame_done(frame_done0), .overrun(overrun0)
    );

    logic [3:0]  vram0 [0:16383];
    logic [21:0] fetch_a0 [0:8191];
    int idx0 = 0, fidx0 = 0, seq_err0 = 0, req0 = 0, done0 = 0, last_wr0 = 0;

    always @(negedge clk) begin
        if (vram_we0) begin
            vram0[vram_wa0] = vram_do0;
            if (vram_wa0 !== {6'(idx0 / 160), 8'(idx0 % 160)}) seq_err0++;
            idx0++;
        end
        if (mem_req0) begin
            req0++;
            if (fidx0 < 8192) fetch_a0[fidx0] = mem_a0;
            fidx0++;
        end
        if (frame_done0) begin
            done0++;
            last_wr0 = idx0;
        end
        if (!busy0) begin
            idx0  = 0;
            fidx0 = 0;
        end
    end

    // ---------------- instance 1: small, inverted, random wait states
    localparam logic [21:0] BASE1 = 22'h012345;
    logic        reset1 = 1'b1, frame_start1 = 1'b0;
    logic        mem_req1, vram_we1, busy1, frame_done1, overrun1;
    logic        ack1 = 1'b0;
    logic [7:0]  di1 = '0;
    logic [21:0] mem_a1, off1;
    logic [13:0] vram_wa1;
    logic [3:0]  vram_do1;

    lcd_vram_fill #(.LINES(4), .BYTES_PER_LINE(8), .INVERT(1'b1)) dut1 (
        .clk25(clk), .reset(reset1), .lcdon(1'b1), .frame_start(frame_start1),
        .base_addr(BASE1), .mem_req(mem_req1), .mem_a(mem_a1), .mem_ack(ack1),
        .mem_di(di1), .vram_we(vram_we1), .vram_wa(vram_wa1), .vram_do(vram_do1),
        .busy(busy1), .frame_done(frame_done1), .overrun(overrun1)
    );

    logic [3:0]  vram1 [0:16383];
    logic        prev_req1 = 1'b0, prev_ack1 = 1'b0;
    logic [21:0] prev_a1 = '0;
    int wait1 = 3, stab_err1 = 0, idx1 = 0, seq_err1 = 0;

    always @(negedge clk) begin
        if (prev_req1 && !prev_ack1 && (!mem_req1 || mem_a1 !== prev_a1)) stab_err1++;
        if (ack1) begin
            ack1  = 1'b0;
            wait1 = $urandom_range(0, 7);
        end else if (mem_req1) begin
            if (wait1 == 0) begin
                ack1 = 1'b1;
                off1 = mem_a1 - BASE1;
                di1  = off1[7:0] * 8'd7 + 8'hA5;
            end else begin
                wait1--;
            end
        end
        prev_req1 = mem_req1;
        prev_ack1 = ack1;
        prev_a1   = mem_a1;
        if (vram_we1) begin
            vram1[vram_wa1] = vram_do1;
            if (vram_wa1 !== {6'(idx1 / 16), 8'(idx1 % 16)}) seq_err1++;
            idx1++;
        end
    end

    // ---------------- helpers
    task automatic run_frame0(input logic [21:0] base, input logic on, input int pulse_at,
                              output int cyc, output logic rose, output logic ov1,
                              output logic ov2, output logic busy_end);
        int k;
        @(negedge clk);
        base_addr0   = base;
        lcdon0       = on;
        frame_start0 = 1'b1;
        @(negedge clk);
        frame_start0 = 1'b0;
        rose = busy0;
        ov1  = 1'b0;
        ov2  = 1'b0;
        k    = 0;
        while (k < 20000) begin
            @(negedge clk);
            k++;
            if (k == pulse_at + 1) ov1 = overrun0;
            if (k == pulse_at + 2) ov2 = overrun0;
            frame_start0 = (k == pulse_at);
            if (frame_done0) break;
        end
        cyc      = frame_done0 ? k : -1;
        busy_end = busy0;
        @(negedge clk);
    endtask

    task automatic vram0_errors(input bit blank, output int errs);
        logic [31:0] off;
        logic [3:0]  e;
        errs = 0;
        for (int l = 0; l < 64; l++) begin
            for (int n = 0; n < 160; n++) begin
                off = 32'(l * 80 + n / 2);
                e   = blank ? 4'h0 : ((n % 2 == 0) ? off[7:4] : off[3:0]);
                if (vram0[l * 256 + n] !== e) errs++;
            end
        end
    endtask

    int          cyc, errs, done_snap, req_snap, k;
    logic        rose, ov1, ov2, busy_end;
    logic [7:0]  b;
    logic [31:0] off;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ctl", {27'd0, busy0, mem_req0, vram_we0, frame_done0, overrun0}, 32'd0);
        check("reset_addr", {10'd0, mem_a0}, 32'd0);
        check("reset_wa_do", {14'd0, vram_wa0, vram_do0}, 32'd0);
        reset0 = 1'b0;
        reset1 = 1'b0;

        // Small inverted instance with random wait states
        @(negedge clk);
        frame_start1 = 1'b1;
        @(negedge clk);
        frame_start1 = 1'b0;
        k = 0;
        while (!frame_done1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("w1_done", {31'd0, frame_done1}, 32'd1);
        check("w1_busy_low", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        check("w1_writes", 32'(idx1), 32'd64);
        check("w1_order", 32'(seq_err1), 32'd0);
        check("w1_stable", 32'(stab_err1), 32'd0);
        check("inv_hi_a5", {28'd0, vram1[0]}, 32'h5);
        check("inv_lo_a5", {28'd0, vram1[1]}, 32'hA);
        errs = 0;
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 8; c++) begin
                b = 8'(l * 8 + c) * 8'd7 + 8'hA5;
                if (vram1[l * 256 + c * 2] !== ~b[7:4]) errs++;
                if (vram1[l * 256 + c * 2 + 1] !== ~b[3:0]) errs++;
            end
        end
        check("w1_contents", 32'(errs), 32'd0);

        // Zero-wait full frame
        done_snap = done0;
        run_frame0(22'h040000, 1'b1, -10, cyc, rose, ov1, ov2, busy_end);
        check("zw_busy_rise", {31'd0, rose}, 32'd1);
        check("zw_cycles", 32'(cyc), 32'd15360);
        check("zw_busy_end", {31'd0, busy_end}, 32'd0);
        check("zw_writes", 32'(last_wr0), 32'd10240);
        check("zw_order", 32'(seq_err0), 32'd0);
        check("zw_first_fetch", {10'd0, fetch_a0[0]}, 32'h040000);
        check("zw_0000", {28'd0, vram0[14'h0000]}, 32'h0);
        check("zw_0001", {28'd0, vram0[14'h0001]}, 32'h0);
        check("zw_0002", {28'd0, vram0[14'h0002]}, 32'h0);
        check("zw_0003", {28'd0, vram0[14'h0003]}, 32'h1);
        check("zw_0100", {28'd0, vram0[14'h0100]}, 32'h5);
        check("zw_0101", {28'd0, vram0[14'h0101]}, 32'h0);
        vram0_errors(1'b0, errs);
        check("zw_contents", 32'(errs), 32'd0);
        check("zw_done_count", 32'(done0 - done_snap), 32'd1);

        // Wrapping base plus an overrun pulse mid-copy
        done_snap = done0;
        run_frame0(22'h3FFFF0, 1'b1, 1000, cyc, rose, ov1, ov2, busy_end);
        check("wrap_a15", {10'd0, fetch_a0[15]}, 32'h3FFFFF);
        check("wrap_a16", {10'd0, fetch_a0[16]}, 32'h000000);
        check("ovr_pulse", {31'd0, ov1}, 32'd1);
        check("ovr_one_cycle", {31'd0, ov2}, 32'd0);
        check("wrap_cycles", 32'(cyc), 32'd15360);
        check("wrap_done_count", 32'(done0 - done_snap), 32'd1);
        vram0_errors(1'b0, errs);
        check("wrap_contents", 32'(errs), 32'd0);

        // LCD off: blank fill, no memory traffic
        req_snap = req0;
        run_frame0(22'h040000, 1'b0, -10, cyc, rose, ov1, ov2, busy_end);
        check("blank_cycles", 32'(cyc), 32'd10240);
        check("blank_no_req", 32'(req0 - req_snap), 32'd0);
        check("blank_writes", 32'(last_wr0), 32'd10240);
        check("blank_order", 32'(seq_err0), 32'd0);
        check("blank_3f9f", {28'd0, vram0[14'h3F9F]}, 32'h0);
        vram0_errors(1'b1, errs);
        check("blank_contents", 32'(errs), 32'd0);

        // Reset in the middle of line 10 (byte 805 = line 10, col 5, WR_HI)
        @(negedge clk);
        base_addr0   = 22'h040000;
        lcdon0       = 1'b1;
        frame_start0 = 1'b1;
        @(negedge clk);
        frame_start0 = 1'b0;
        repeat (2416) @(negedge clk);
        check("pre_rst_we", {17'd0, vram_we0, vram_wa0}, {17'd0, 1'b1, 14'h0A0A});
        reset0 = 1'b1;
        #1;
        check("rst_async_ctl", {27'd0, busy0, mem_req0, vram_we0, frame_done0, overrun0}, 32'd0);
        check("rst_async_addr", {10'd0, mem_a0}, 32'd0);
        check("rst_async_wa_do", {14'd0, vram_wa0, vram_do0}, 32'd0);
        done_snap = done0;
        @(negedge clk);
        reset0 = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_done", 32'(done0 - done_snap), 32'd0);

        // Restart after abort: must begin again at line 0, col 0
        run_frame0(22'h001000, 1'b1, -10, cyc, rose, ov1, ov2, busy_end);
        check("restart_fetch0", {10'd0, fetch_a0[0]}, 32'h001000);
        check("restart_cycles", 32'(cyc), 32'd15360);
        check("restart_order", 32'(seq_err0), 32'd0);
        check("restart_writes", 32'(last_wr0), 32'd10240);
        vram0_errors(1'b0, errs);
        check("restart_contents", 32'(errs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
